rr_arb_mux: RTL and testbench



---
 rtl/rr_arb_mux.sv | 62 ++++++
 tb/tb_rr_arb_mux.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/rr_arb_mux.sv
// rr_arb_mux: N-channel round-robin/fixed-priority arbitrated mux with a registered valid/ready output stage.
module rr_arb_mux #(
   parameter int LENGTH        = 32,
   parameter int CHANNELS      = 4,
   parameter int PRIORITY_MODE = 0,
   parameter int SEL_W         = $clog2(CHANNELS)
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [CHANNELS*LENGTH-1:0]   in_data,
   input  logic [CHANNELS-1:0]          in_valid,
   output logic [CHANNELS-1:0]          in_ready,
   output logic [LENGTH-1:0]            out_data,
   output logic [SEL_W-1:0]             out_sel,
   output logic                         out_valid,
   input  logic                         out_ready,
   input  logic                         flush
);
   logic [SEL_W-1:0]  g, idx, ptr_q, ptr_d, sel_q, sel_d;
   logic [LENGTH-1:0] g_data, data_q, data_d;
   logic              valid_q, valid_d, load, accept;
   int                base;
   always_comb begin
      base = PRIORITY_MODE != 0 ? 0 : int'(ptr_q);
      g    = '0;
      idx  = '0;
      for (int k = CHANNELS - 1; k >= 0; k--) begin
         idx = SEL_W'((base + k) % CHANNELS);
         if (in_valid[idx]) g = idx;
      end
   end
   always_comb begin
      g_data = '0;
      for (int i = 0; i < CHANNELS; i++)
         if (g == SEL_W'(i)) g_data = in_data[i*LENGTH +: LENGTH];
   end
   always_comb begin
      load    = !flush && (!valid_q || out_ready);
      accept  = rst_n && load && |in_valid;
      valid_d = flush ? 1'b0 : accept ? 1'b1 : out_ready ? 1'b0 : valid_q;
      data_d  = accept ? g_data : data_q;
      sel_d   = accept ? g : sel_q;
      ptr_d   = !accept ? ptr_q : (g == SEL_W'(CHANNELS - 1)) ? '0 : g + 1'b1;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         sel_q   <= '0;
         ptr_q   <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         sel_q   <= sel_d;
         ptr_q   <= ptr_d;
      end
   end
   assign in_ready  = accept ? CHANNELS'(1) << g : '0;
   assign out_data  = data_q;
   assign out_sel   = sel_q;
   assign out_valid = valid_q;
endmodule

// File: tb/tb_rr_arb_mux.sv
// tb_rr_arb_mux: table vectors, hand sequences and random stimulus against a spec-level model, both arbitration modes.
module tb_rr_arb_mux;
   logic        clk = 1'b0, rst_n = 1'b0, out_ready = 1'b0, flush = 1'b0;
   logic [31:0] in_data = '0;
   logic [3:0]  in_valid = '0, rdy0, rdy1;
   logic [7:0]  od0, od1;
   logic [1:0]  os0, os1;
   logic        ov0, ov1;
   int          errors = 0, checks = 0;
   int          m_ptr[2];
   bit          m_ov[2];
   logic [7:0]  m_d[2];
   logic [1:0]  m_sel[2];

   always #5 clk = ~clk;

   rr_arb_mux #(.LENGTH(8), .CHANNELS(4), .PRIORITY_MODE(0)) dut (
      .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy0),
      .out_data(od0), .out_sel(os0), .out_valid(ov0), .out_ready(out_ready), .flush(flush));
   rr_arb_mux #(.LENGTH(8), .CHANNELS(4), .PRIORITY_MODE(1)) dut_fp (
      .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy1),
      .out_data(od1), .out_sel(os1), .out_valid(ov1), .out_ready(out_ready), .flush(flush));

   typedef struct {
      logic [3:0]  v;
      logic [31:0] d;
      logic        ordy;
      logic        fl;
      logic [3:0]  rdy;
      logic        ov;
      logic [7:0]  od;
      logic [1:0]  os;
   } vec_t;
   vec_t tbl[17];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int grant(int m);
      int base = (m == 1) ? 0 : m_ptr[m];
      for (int k = 0; k < 4; k++)
         if (in_valid[(base + k) % 4]) return (base + k) % 4;
      return -1;
   endfunction

   function automatic logic [3:0] exp_rdy(int m);
      int g = grant(m);
      if (!rst_n || flush || (m_ov[m] && !out_ready) || g < 0) return 4'b0000;
      return 4'b0001 << g;
   endfunction

   task automatic model_reset();
      for (int m = 0; m < 2; m++) begin
         m_ptr[m] = 0; m_ov[m] = 0; m_d[m] = '0; m_sel[m] = '0;
      end
   endtask

   task automatic model_edge();
      for (int m = 0; m < 2; m++) begin
         int g = grant(m);
         if (exp_rdy(m) != 4'b0000) begin
            m_d[m]   = in_data[g*8 +: 8];
            m_sel[m] = 2'(g);
            m_ov[m]  = 1;
            m_ptr[m] = (g + 1) % 4;
         end else if (flush || out_ready) m_ov[m] = 0;
      end
   endtask

   task automatic check_pre();
      chk("rr in_ready", {28'b0, rdy0}, {28'b0, exp_rdy(0)});
      chk("fp in_ready", {28'b0, rdy1}, {28'b0, exp_rdy(1)});
   endtask

   task automatic check_post();
      chk("rr out_valid", {31'b0, ov0}, {31'b0, m_ov[0]});
      chk("rr out_data", {24'b0, od0}, {24'b0, m_d[0]});
      chk("rr out_sel", {30'b0, os0}, {30'b0, m_sel[0]});
      chk("fp out_valid", {31'b0, ov1}, {31'b0, m_ov[1]});
      chk("fp out_data", {24'b0, od1}, {24'b0, m_d[1]});
      chk("fp out_sel", {30'b0, os1}, {30'b0, m_sel[1]});
   endtask

   task automatic step();
      #3 check_pre();
      @(posedge clk);
      model_edge();
      #1 check_post();
   endtask

   task automatic check_reset(input string tag);
      chk({tag, " out_valid"}, {30'b0, ov1, ov0}, 32'h0);
      chk({tag, " out_data"}, {od1, od0}, 32'h0);
      chk({tag, " out_sel"}, {os1, os0}, 32'h0);
      chk({tag, " in_ready"}, {rdy1, rdy0}, 32'h0);
   endtask

   initial begin
      tbl[0]  = '{4'b1111, 32'h40302010, 1, 0, 4'b0001, 1, 8'h10, 0};
      tbl[1]  = '{4'b1111, 32'h40302010, 1, 0, 4'b0010, 1, 8'h20, 1};
      tbl[2]  = '{4'b1111, 32'h40302010, 1, 0, 4'b0100, 1, 8'h30, 2};
      tbl[3]  = '{4'b1111, 32'h40302010, 1, 0, 4'b1000, 1, 8'h40, 3};
      tbl[4]  = '{4'b1111, 32'h40302010, 1, 0, 4'b0001, 1, 8'h10, 0};
      tbl[5]  = '{4'b1111, 32'h40302010, 1, 0, 4'b0010, 1, 8'h20, 1};
      tbl[6]  = '{4'b1111, 32'h40302010, 0, 0, 4'b0000, 1, 8'h20, 1};
      tbl[7]  = '{4'b1111, 32'h40302010, 0, 0, 4'b0000, 1, 8'h20, 1};
      tbl[8]  = '{4'b1111, 32'h40302010, 0, 0, 4'b0000, 1, 8'h20, 1};
      tbl[9]  = '{4'b1111, 32'h40302010, 1, 0, 4'b0100, 1, 8'h30, 2};
      tbl[10] = '{4'b0100, 32'h40302010, 0, 1, 4'b0000, 0, 8'h30, 2};
      tbl[11] = '{4'b0100, 32'h40372010, 0, 0, 4'b0100, 1, 8'h37, 2};
      tbl[12] = '{4'b0000, 32'h40372010, 1, 0, 4'b0000, 0, 8'h37, 2};
      tbl[13] = '{4'b1010, 32'hA330A110, 1, 0, 4'b1000, 1, 8'hA3, 3};
      tbl[14] = '{4'b1010, 32'hA330A110, 1, 0, 4'b0010, 1, 8'hA1, 1};
      tbl[15] = '{4'b1010, 32'hA330A110, 1, 0, 4'b1000, 1, 8'hA3, 3};
      tbl[16] = '{4'b1010, 32'hA330A110, 1, 0, 4'b0010, 1, 8'hA1, 1};
      model_reset();
      in_valid = 4'b1111;
      #1 check_reset("reset");
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;
      for (int i = 0; i < 17; i++) begin
         in_valid  = tbl[i].v;
         in_data   = tbl[i].d;
         out_ready = tbl[i].ordy;
         flush     = tbl[i].fl;
         #3 chk($sformatf("vec%0d in_ready", i), {28'b0, rdy0}, {28'b0, tbl[i].rdy});
         check_pre();
         @(posedge clk);
         model_edge();
         #1 chk($sformatf("vec%0d out_valid", i), {31'b0, ov0}, {31'b0, tbl[i].ov});
         chk($sformatf("vec%0d out_data", i), {24'b0, od0}, {24'b0, tbl[i].od});
         chk($sformatf("vec%0d out_sel", i), {30'b0, os0}, {30'b0, tbl[i].os});
         check_post();
      end
      #1 rst_n = 1'b0;
      #1 check_reset("midreset");
      model_reset();
      @(posedge clk);
      #1 rst_n = 1'b1;
      in_valid = 4'b1111;
      in_data  = 32'h40302010;
      out_ready = 1'b1;
      step();
      chk("restart sel", {30'b0, os0}, 32'd0);
      in_valid = 4'b0101;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("fp hold ch0", {30'b0, os1}, 32'd0);
      end
      in_valid = 4'b0100;
      step();
      chk("fp drop ch0", {30'b0, os1}, 32'd2);
      chk("fp drop data", {24'b0, od1}, 32'h30);
      for (int i = 0; i < 400; i++) begin
         in_valid  = 4'($urandom);
         in_data   = $urandom;
         out_ready = $urandom_range(0, 3) != 0;
         flush     = $urandom_range(0, 15) == 0;
         step();
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
